// File: rtl/pumpen_leadlag_ctrl.sv
// Lead/lag scheduler for a two-pump drainage station: synchronized level sensors drive a
// four-state controller with minimum on/off times, delayed lag start and lead rotation.
module pumpen_leadlag_ctrl #(
    parameter int unsigned MIN_ON    = 16,
    parameter int unsigned MIN_OFF   = 16,
    parameter int unsigned LAG_DELAY = 32,
    parameter int unsigned CW        = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] x_i,
    output logic [1:0] y_o,
    output logic       lead_o,
    output logic       fault_o
);

    typedef enum logic [1:0] {StIdle, StLead, StBoth, StFault} state_e;

    localparam logic [CW-1:0] MinOn    = CW'(MIN_ON);
    localparam logic [CW-1:0] MinOff   = CW'(MIN_OFF);
    localparam logic [CW-1:0] LagDelay = CW'(LAG_DELAY);

    state_e        st_q, st_d;
    logic [2:0]    sync1_q, sync2_q;
    logic          lead_q, lead_d;
    logic          fault_q, fault_d;
    logic [1:0]    y_q, y_d;
    logic [CW-1:0] off_q, off_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] lag_q, lag_d;
    logic [CW-1:0] off_inc, run_inc, lag_inc;
    logic          lvl_l, lvl_h, lvl_a, fault_cond;

    // Saturating increment; the incremented value counts the current cycle as elapsed.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return (v >= lim) ? lim : v + CW'(1);
    endfunction

    assign lvl_l      = sync2_q[0];
    assign lvl_h      = sync2_q[1];
    assign lvl_a      = sync2_q[2];
    assign fault_cond = (lvl_h & ~lvl_l) | (lvl_a & ~lvl_h);

    assign off_inc = sat_inc(off_q, MinOff);
    assign run_inc = sat_inc(run_q, MinOn);
    assign lag_inc = sat_inc(lag_q, LagDelay);

    always_comb begin
        st_d   = st_q;
        lead_d = lead_q;
        off_d  = '0;
        run_d  = run_q;
        lag_d  = '0;
        unique case (st_q)
            StIdle: begin
                off_d = off_inc;
                if (fault_cond) begin
                    st_d  = StFault;
                    off_d = '0;
                end else if (lvl_h && (off_inc >= MinOff)) begin
                    st_d  = StLead;
                    off_d = '0;
                    run_d = '0;
                end
            end
            StLead: begin
                run_d = run_inc;
                lag_d = lvl_h ? lag_inc : '0;
                if (fault_cond) begin
                    st_d  = StFault;
                    lag_d = '0;
                end else if (!lvl_l && (run_inc >= MinOn)) begin
                    st_d   = StIdle;
                    lead_d = ~lead_q;
                    lag_d  = '0;
                end else if (lvl_a || (lvl_h && (lag_inc >= LagDelay))) begin
                    st_d  = StBoth;
                    lag_d = '0;
                end
            end
            StBoth: begin
                run_d = run_inc;
                if (fault_cond) begin
                    st_d = StFault;
                end else if (!lvl_l && (run_inc >= MinOn)) begin
                    st_d   = StIdle;
                    lead_d = ~lead_q;
                end
            end
            StFault: begin
                st_d = StFault;
            end
        endcase

        fault_d = (st_d == StFault);
        y_d     = 2'b00;
        unique case (st_d)
            StLead:  y_d = lead_d ? 2'b10 : 2'b01;
            StBoth:  y_d = 2'b11;
            default: y_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            st_q    <= StIdle;
            lead_q  <= 1'b0;
            fault_q <= 1'b0;
            y_q     <= 2'b00;
            off_q   <= MinOff;
            run_q   <= '0;
            lag_q   <= '0;
        end else begin
            sync1_q <= x_i;
            sync2_q <= sync1_q;
            st_q    <= st_d;
            lead_q  <= lead_d;
            fault_q <= fault_d;
            y_q     <= y_d;
            off_q   <= off_d;
            run_q   <= run_d;
            lag_q   <= lag_d;
        end
    end

    assign y_o     = y_q;
    assign lead_o  = lead_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_pumpen_leadlag_ctrl.sv
// Bench for pumpen_leadlag_ctrl: directed scenarios with literal expectations, then random
// sensor patterns checked every cycle against a cycle-count model of the station.
module tb_pumpen_leadlag_ctrl;

    localparam int unsigned MinOn    = 4;
    localparam int unsigned MinOff   = 4;
    localparam int unsigned LagDelay = 8;

    localparam int MIdle  = 0;
    localparam int MLead  = 1;
    localparam int MBoth  = 2;
    localparam int MFault = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] x   = 3'b111;
    logic [1:0] y;
    logic       lead;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    pumpen_leadlag_ctrl #(
        .MIN_ON   (MinOn),
        .MIN_OFF  (MinOff),
        .LAG_DELAY(LagDelay),
        .CW       (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .x_i    (x),
        .y_o    (y),
        .lead_o (lead),
        .fault_o(fault)
    );

    always #5 clk = ~clk;

    // Model: sensor pipeline plus elapsed-cycle counts per state, plain integers.
    bit       m_valid = 1'b0;
    bit [2:0] m_s1, m_s2;
    int       m_mode;
    bit       m_lead;
    int       m_idle, m_run, m_hi;
    bit       ml, mh, ma;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_s1    = 3'b000;
            m_s2    = 3'b000;
            m_mode  = MIdle;
            m_lead  = 1'b0;
            m_idle  = MinOff;
            m_run   = 0;
            m_hi    = 0;
        end else if (m_valid) begin
            ml = m_s2[0];
            mh = m_s2[1];
            ma = m_s2[2];
            if (m_mode != MFault && ((mh && !ml) || (ma && !mh))) begin
                m_mode = MFault;
            end else if (m_mode == MIdle) begin
                m_idle++;
                if (mh && m_idle >= MinOff) begin
                    m_mode = MLead;
                    m_run  = 0;
                    m_hi   = 0;
                end
            end else if (m_mode == MLead || m_mode == MBoth) begin
                m_run++;
                m_hi = mh ? m_hi + 1 : 0;
                if (!ml && m_run >= MinOn) begin
                    m_mode = MIdle;
                    m_lead = !m_lead;
                    m_idle = 0;
                end else if (m_mode == MLead && (ma || (mh && m_hi >= LagDelay))) begin
                    m_mode = MBoth;
                end
            end
            m_s2 = m_s1;
            m_s1 = x;
        end
    end

    function automatic logic [1:0] model_y();
        case (m_mode)
            MLead:   return m_lead ? 2'b10 : 2'b01;
            MBoth:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_y", y, model_y());
            chk("model_lead", {1'b0, lead}, {1'b0, m_lead});
            chk("model_fault", {1'b0, fault}, {1'b0, (m_mode == MFault)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] valid_pat [4];
    logic [2:0] bad_pat   [4];

    initial begin
        valid_pat = '{3'b000, 3'b001, 3'b011, 3'b111};
        bad_pat   = '{3'b010, 3'b100, 3'b101, 3'b110};

        // Reset with all sensors high, then released with sensors low.
        cyc(1);
        chk("rst1_y", y, 2'b00);
        chk("rst1_fault", {1'b0, fault}, 2'b00);
        cyc(1);
        chk("rst2_y", y, 2'b00);
        chk("rst2_lead", {1'b0, lead}, 2'b00);
        rst = 1'b0;
        x   = 3'b000;
        cyc(3);
        chk("idle_y", y, 2'b00);

        // Normal cycle and rotation.
        x = 3'b011;
        cyc(2);
        chk("start_edge2_y", y, 2'b00);
        cyc(1);
        chk("start_edge3_y", y, 2'b01);
        x = 3'b001;
        cyc(10);
        chk("run_y", y, 2'b01);
        x = 3'b000;
        cyc(2);
        chk("stop_edge2_y", y, 2'b01);
        cyc(1);
        chk("stop_edge3_y", y, 2'b00);
        chk("rotate_lead", {1'b0, lead}, 2'b01);
        cyc(6);
        x = 3'b011;
        cyc(3);
        chk("b_lead_y", y, 2'b10);
        x = 3'b000;
        cyc(8);
        chk("b_stop_y", y, 2'b00);
        chk("b_stop_lead", {1'b0, lead}, 2'b00);

        // Minimum on time, then minimum off time.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        x   = 3'b011;
        cyc(3);
        chk("minon_entry_y", y, 2'b01);
        x = 3'b000;
        cyc(3);
        chk("minon_hold_y", y, 2'b01);
        cyc(1);
        chk("minon_stop_y", y, 2'b00);
        chk("minon_lead", {1'b0, lead}, 2'b01);
        x = 3'b011;
        cyc(3);
        chk("minoff_hold_y", y, 2'b00);
        cyc(1);
        chk("minoff_start_y", y, 2'b10);

        // Alarm brings in the lag pump; reset in BOTH clears everything at once.
        x = 3'b111;
        cyc(2);
        chk("alarm_edge2_y", y, 2'b10);
        cyc(1);
        chk("alarm_edge3_y", y, 2'b11);
        rst = 1'b1;
        cyc(1);
        chk("rst_both_y", y, 2'b00);
        chk("rst_both_lead", {1'b0, lead}, 2'b00);

        // Lag pump after a sustained high level.
        rst = 1'b0;
        x   = 3'b011;
        cyc(3);
        chk("lag_entry_y", y, 2'b01);
        cyc(7);
        chk("lag_wait_y", y, 2'b01);
        cyc(1);
        chk("lag_both_y", y, 2'b11);

        // Fault latches until reset.
        x = 3'b010;
        cyc(2);
        chk("fault_edge2", {1'b0, fault}, 2'b00);
        cyc(1);
        chk("fault_edge3", {1'b0, fault}, 2'b01);
        chk("fault_y", y, 2'b00);
        x = 3'b011;
        cyc(5);
        chk("fault_latched", {1'b0, fault}, 2'b01);
        chk("fault_latched_y", y, 2'b00);
        rst = 1'b1;
        cyc(1);
        chk("fault_cleared", {1'b0, fault}, 2'b00);
        rst = 1'b0;
        x   = 3'b000;
        cyc(3);

        // Random sensor sequences with occasional faults and resets.
        for (int seg = 0; seg < 400; seg++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) x = bad_pat[$urandom_range(0, 3)];
            else x = valid_pat[r % 4];
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc(int'($urandom_range(1, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
